// File: rtl/board_state_ram.sv
// Pac-Man tile-map store: display read port, valid/ready game write port, registered query port,
// power-up maze sweep and live food counter. Optional macro BOARD_VBLANK_WRITES_EN gates writes to vblank.
module board_state_ram #(
    parameter int COLS      = 32,
    parameter int ROWS      = 24,
    parameter int FOOD_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           x,
    input  logic [5:0]           y,
    output logic [2:0]           board_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [5:0]           wr_x,
    input  logic [5:0]           wr_y,
    input  logic [2:0]           wr_data,
    input  logic [5:0]           q_x,
    input  logic [5:0]           q_y,
    output logic [2:0]           q_data,
    input  logic                 vblank,
    output logic                 init_done,
    output logic [FOOD_BITS-1:0] food_left,
    output logic                 all_eaten
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [2:0] TILE_FOOD = 3'd1;
    localparam logic [2:0] TILE_WALL = 3'd2;

    typedef enum logic [1:0] {INIT, SWEEP, RUN} state_t;

    state_t               state_q, state_d;
    logic [2:0]           cells [CELLS];
    logic [5:0]           sx_q, sy_q;
    logic [IDX_W-1:0]     sweep_idx, wr_idx, rd_idx, q_idx;
    logic                 sweep_last, sweep_border;
    logic                 wr_fire, wr_in_range, rd_in_range, q_in_range;
    logic                 old_food, new_food;
    logic [FOOD_BITS-1:0] food_d;

    function automatic logic [IDX_W-1:0] cell_index(input logic [5:0] cx, input logic [5:0] cy);
        logic [15:0] lin;
        lin = 16'(cy) * 16'(COLS) + 16'(cx);
        return lin[IDX_W-1:0];
    endfunction

    function automatic logic in_bounds(input logic [5:0] cx, input logic [5:0] cy);
        return (32'(cx) < COLS) && (32'(cy) < ROWS);
    endfunction

    function automatic logic is_food(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd5);
    endfunction

`ifdef BOARD_VBLANK_WRITES_EN
    assign wr_ready = (state_q == RUN) && vblank;
`else
    logic vblank_unused;
    assign vblank_unused = vblank;
    assign wr_ready      = (state_q == RUN);
`endif

    assign sweep_idx    = cell_index(sx_q, sy_q);
    assign sweep_last   = (32'(sx_q) == COLS - 1) && (32'(sy_q) == ROWS - 1);
    assign sweep_border = (sx_q == '0) || (sy_q == '0) ||
                          (32'(sx_q) == COLS - 1) || (32'(sy_q) == ROWS - 1);

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = in_bounds(wr_x, wr_y);
    assign wr_idx      = cell_index(wr_x, wr_y);
    assign rd_in_range = in_bounds(x, y);
    assign rd_idx      = cell_index(x, y);
    assign q_in_range  = in_bounds(q_x, q_y);
    assign q_idx       = cell_index(q_x, q_y);

    assign board_data = ((state_q == RUN) && rd_in_range) ? cells[rd_idx] : '0;
    assign init_done  = (state_q == RUN);
    assign all_eaten  = (food_left == '0) && init_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = SWEEP;
            SWEEP:   if (sweep_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Food delta is taken from the cell contents before this edge's write lands.
    always_comb begin
        food_d   = food_left;
        old_food = is_food(cells[wr_idx]);
        new_food = is_food(wr_data);
        if (state_q == SWEEP) begin
            if (!sweep_border && (food_left != '1)) food_d = food_left + 1'b1;
        end else if (wr_fire && wr_in_range) begin
            if (old_food && !new_food && (food_left != '0)) food_d = food_left - 1'b1;
            else if (!old_food && new_food && (food_left != '1)) food_d = food_left + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == SWEEP)
            cells[sweep_idx] <= sweep_border ? TILE_WALL : TILE_FOOD;
        else if (wr_fire && wr_in_range)
            cells[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            sx_q      <= '0;
            sy_q      <= '0;
            food_left <= '0;
            q_data    <= '0;
        end else begin
            state_q   <= state_d;
            food_left <= food_d;
            q_data    <= ((state_q == RUN) && q_in_range) ? cells[q_idx] : '0;
            if (state_q == SWEEP) begin
                if (32'(sx_q) == COLS - 1) begin
                    sx_q <= '0;
                    sy_q <= sy_q + 6'd1;
                end else begin
                    sx_q <= sx_q + 6'd1;
                end
            end
        end
    end

endmodule

// File: doc/board_state_ram.md
Name: board_state_ram

Overview:
- Tile-map store for the Pac-Man board. It is the responder side of the display fetch interface: the VGA scan logic drives tile coordinates x/y and this block returns the 3-bit tile code on board_data.
- It also accepts tile updates from the game FSM over a valid/ready write port and serves a registered game-side query port.
- It runs a power-up maze initialisation sweep.
- It maintains a live count of remaining food.

Parameters:
- COLS, 32, tile columns (640 px / 20 px tile).
- ROWS, 24, tile rows (480 px / 20 px tile).
- FOOD_BITS, 10, width of food_left counter.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain)
- rst_n  input  1  asynchronous active-low reset
- x  input  6  display tile column
- y  input  6  display tile row
- board_data  output  3  tile code at (x,y), combinational
- wr_valid  input  1  game write request
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- wr_x  input  6  write column
- wr_y  input  6  write row
- wr_data  input  3  new tile code
- q_x  input  6  query column
- q_y  input  6  query row
- q_data  output  3  registered query result
- vblank  input  1  vertical blanking flag (used only with the optional feature)
- init_done  output  1  high once the init sweep completes
- food_left  output  FOOD_BITS  number of cells holding food or ghost_and_food
- all_eaten  output  1  food_left == 0 && init_done

Behaviour:
- Tile codes: empty=0, food=1, wall=2, pacman=3, ghost=4, ghost_and_food=5. Codes 6 and 7 are stored verbatim and count as non-food.
- Storage: COLS*ROWS x 3-bit register array, row-major, index y*COLS+x.
- Reset (rst_n low, asynchronous):
  - FSM goes to INIT and the sweep counter to 0.
  - init_done=0, wr_ready=0, food_left=0, q_data=0.
  - Array contents are don't-care.
- FSM states:
  - INIT (1 cycle): goes to SWEEP.
  - SWEEP (COLS*ROWS cycles): writes one cell per cycle in row-major order. Border cells (x==0, x==COLS-1, y==0, y==ROWS-1) get wall; all others get food. food_left increments for each food write. After the last cell (index 767), goes to RUN.
  - RUN: terminal state.
- init_done rises on the first RUN cycle, 1+768 cycles after rst_n deasserts. food_left is then 660.
- wr_ready=1 only in RUN (subject to the optional feature). Writes offered earlier stall and are not lost by this block; the master holds them.
- Accepted write: the cell updates at the clock edge. food_left adjusts in the same edge:
  - old cell food-bearing (1 or 5), new not food-bearing: -1.
  - old not food-bearing, new food-bearing: +1.
  - otherwise unchanged.
  - The counter saturates at 0 and at 2^FOOD_BITS-1.
- Out-of-range write (wr_x>=COLS or wr_y>=ROWS): handshake completes, array and count unchanged.
- Display read: board_data = cell(x,y) combinationally, zero latency. The read shows pre-write contents in the cycle a write to the same cell is accepted, and new contents from the next cycle on. Out-of-range (x,y) returns 0. During INIT/SWEEP, board_data returns 0 for every cell.
- Query: q_data registers cell(q_x,q_y) with 1-cycle latency. Out-of-range returns 0. A same-cycle write to the queried cell returns the old value (read-before-write).
- all_eaten is combinational from registered state.
- rst_n asserted mid-sweep or mid-RUN: immediate return to the reset values above, then the sweep restarts from index 0.

Optional Feature:
- Macro: BOARD_VBLANK_WRITES_EN.
- Defined: wr_ready = RUN && vblank. Display never sees a tile change mid-frame.
- Undefined: vblank is ignored and wr_ready = RUN.

Test Plan:
- Release rst_n, count cycles -> init_done rises exactly 769 cycles later; food_left=660; board_data at (0,0)=2, (5,5)=1, (31,23)=2, (40,3)=0.
- In RUN, write (5,5)<=0 -> food_left 660->659 on the same edge; next cycle board_data at (5,5)=0; a query of (5,5) one cycle later returns 0.
- Write (6,6)<=4 then (6,6)<=5 -> food_left 660->659->660; query returns 5.
- Same cycle: write (7,7)<=3 with q_x/q_y=(7,7) -> q_data=1 next cycle; a query in the following cycle returns 3. Write (33,2) -> handshake completes, food_left unchanged.
- Assert rst_n low at sweep index 300, release -> init_done low, then high 769 cycles after release; food_left=660.
- With BOARD_VBLANK_WRITES_EN defined, vblank=0 and wr_valid=1 -> wr_ready=0 and no change; raise vblank -> write accepted that cycle.
